// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier controller: four 4x4 partial products through one shared
// external multiplier, accumulated at 17 bits, with wrap or saturate on the 16-bit result.
module mult_8x8_seq_ctrl #(
  parameter bit SAT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [7:0]  cfg_mode,
  input  logic        flush,
  output logic        mul_en,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic [1:0]  mul_mode,
  input  logic [7:0]  mul_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r,
  output logic        busy
);

  localparam int unsigned OPW  = 8;
  localparam int unsigned NIBW = 4;
  localparam int unsigned ACCW = 17;
  localparam int unsigned RESW = 16;
  localparam int unsigned MULW = 1 + 2 * NIBW + 2;

  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

  state_t            state;
  logic [OPW-1:0]    a_q;
  logic [OPW-1:0]    b_q;
  logic [OPW-1:0]    cfg_q;
  logic [ACCW-1:0]   acc;

  logic [ACCW-1:0]   pp_c;
  logic [ACCW-1:0]   sum_c;
  logic [RESW-1:0]   res_c;
  state_t            nxt_c;

  // Shared-multiplier drive for a given state: {en, a nibble, b nibble, mode}.
  function automatic logic [MULW-1:0] sched(input state_t s, input logic [OPW-1:0] a,
                                            input logic [OPW-1:0] b, input logic [OPW-1:0] c);
    case (s)
      PP0:     sched = {1'b1, a[3:0], b[3:0], c[1:0]};
      PP1:     sched = {1'b1, a[3:0], b[7:4], c[3:2]};
      PP2:     sched = {1'b1, a[7:4], b[3:0], c[5:4]};
      PP3:     sched = {1'b1, a[7:4], b[7:4], c[7:6]};
      default: sched = '0;
    endcase
  endfunction

  // Partial-product alignment and the next quadrant in the fixed schedule.
  always_comb begin
    pp_c  = '0;
    nxt_c = DONE;
    case (state)
      PP0:     begin pp_c = ACCW'(mul_r);        nxt_c = PP1; end
      PP1:     begin pp_c = ACCW'(mul_r) << 4;   nxt_c = PP2; end
      PP2:     begin pp_c = ACCW'(mul_r) << 4;   nxt_c = PP3; end
      PP3:     begin pp_c = ACCW'(mul_r) << 8;   nxt_c = DONE; end
      default: begin pp_c = '0;                  nxt_c = DONE; end
    endcase
    sum_c = acc + pp_c;
  end

  always_comb begin
    res_c = (SAT && acc[ACCW-1]) ? {RESW{1'b1}} : acc[RESW-1:0];
  end

  // out_r is loaded from the settled accumulator on the first DONE cycle, so
  // out_valid rises one cycle after DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cfg_q     <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      {mul_en, mul_a, mul_b, mul_mode} <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            a_q      <= in_a;
            b_q      <= in_b;
            cfg_q    <= cfg_mode;
            acc      <= '0;
            state    <= PP0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            {mul_en, mul_a, mul_b, mul_mode} <= sched(PP0, in_a, in_b, cfg_mode);
          end
        end
        PP0, PP1, PP2, PP3: begin
          if (flush) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            {mul_en, mul_a, mul_b, mul_mode} <= '0;
          end else begin
            acc   <= sum_c;
            state <= nxt_c;
            {mul_en, mul_a, mul_b, mul_mode} <= sched(nxt_c, a_q, b_q, cfg_q);
          end
        end
        DONE: begin
          if (flush || (out_valid && out_ready)) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end else if (!out_valid) begin
            out_r     <= res_c;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          {mul_en, mul_a, mul_b, mul_mode} <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Directed bench for mult_8x8_seq_ctrl: wrap and saturate instances side by side,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_mult_8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready, stub;
  logic [7:0]  in_a, in_b, cfg_mode;

  logic        in_ready0, mul_en0, out_valid0, busy0;
  logic [3:0]  mul_a0, mul_b0;
  logic [1:0]  mul_mode0;
  logic [7:0]  mul_r0;
  logic [15:0] out_r0;
  logic        in_ready1, mul_en1, out_valid1, busy1;
  logic [3:0]  mul_a1, mul_b1;
  logic [1:0]  mul_mode1;
  logic [7:0]  mul_r1;
  logic [15:0] out_r1;

  int total = 0;
  int bad   = 0;
  logic [9:0] trace [4];

  always #5 clk = ~clk;

  assign mul_r0 = stub ? 8'hFF : ({4'b0, mul_a0} * {4'b0, mul_b0});
  assign mul_r1 = stub ? 8'hFF : ({4'b0, mul_a1} * {4'b0, mul_b1});

  mult_8x8_seq_ctrl #(.SAT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .cfg_mode(cfg_mode), .flush(flush),
    .mul_en(mul_en0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_mode(mul_mode0),
    .mul_r(mul_r0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_r(out_r0), .busy(busy0));

  mult_8x8_seq_ctrl #(.SAT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .cfg_mode(cfg_mode), .flush(flush),
    .mul_en(mul_en1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_mode(mul_mode1),
    .mul_r(mul_r1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_r(out_r1), .busy(busy1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one operation tracked by its age in cycles since acceptance.
  logic        m_busy;
  int          m_age;
  int          m_res;
  logic [7:0]  m_a, m_b, m_cfg;
  logic [15:0] m_r0, m_r1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_age <= 0; m_res <= 0;
      m_a <= '0; m_b <= '0; m_cfg <= '0; m_r0 <= '0; m_r1 <= '0;
    end else if (m_busy) begin
      if (flush) m_busy <= 1'b0;
      else if (m_age >= 5) begin
        if (out_ready) m_busy <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (m_age == 4) begin
          m_r0 <= m_res[15:0];
          m_r1 <= (m_res > 32'hFFFF) ? 16'hFFFF : m_res[15:0];
        end
      end
    end else if (in_valid && !flush) begin
      m_busy <= 1'b1; m_age <= 0;
      m_a <= in_a; m_b <= in_b; m_cfg <= cfg_mode;
      m_res <= stub ? 32'h11FDF : (int'(in_a) * int'(in_b));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic       e_en;
      logic [3:0] e_a, e_b;
      logic [1:0] e_m;
      e_en = m_busy && (m_age <= 3);
      e_a  = !e_en ? 4'h0 : (m_age >= 2 ? m_a[7:4] : m_a[3:0]);
      e_b  = !e_en ? 4'h0 : (m_age[0]   ? m_b[7:4] : m_b[3:0]);
      e_m  = !e_en ? 2'h0 : 2'((m_cfg >> (2 * m_age)) & 8'h3);
      chk("in_ready",  {in_ready1, in_ready0},   {2{!m_busy}});
      chk("busy",      {busy1, busy0},           {2{m_busy}});
      chk("out_valid", {out_valid1, out_valid0}, {2{m_busy && m_age >= 5}});
      chk("mul_en",    {mul_en1, mul_en0},       {2{e_en}});
      chk("mul_ab",    {mul_a0, mul_b0, mul_a1, mul_b1}, {e_a, e_b, e_a, e_b});
      chk("mul_mode",  {mul_mode1, mul_mode0},   {e_m, e_m});
      chk("out_r0",    out_r0, m_r0);
      chk("out_r1",    out_r1, m_r1);
    end
  end

  // Issue one operation; returns at the negedge where out_valid is first seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int lat;
    @(negedge clk);
    in_a = a; in_b = b; cfg_mode = c; in_valid = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom); cfg_mode = 8'($urandom);
      end
      if (k < 4) trace[k] = {mul_a0, mul_b0, mul_mode0};
      if (out_valid0) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
    chk("latency", lat, 5);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; stub = 1'b0;
    in_a = '0; in_b = '0; cfg_mode = '0;
    #12;
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_out", {out_valid0, out_r0}, 17'h0);
    @(negedge clk) rst_n = 1'b1;

    run_op(8'hFF, 8'hFF, 8'h00);
    chk("ffxff", out_r0, 16'hFE01);

    run_op(8'h12, 8'h34, 8'hE4);
    chk("trace_pp0", trace[0], {4'h2, 4'h4, 2'b00});
    chk("trace_pp1", trace[1], {4'h2, 4'h3, 2'b01});
    chk("trace_pp2", trace[2], {4'h1, 4'h4, 2'b10});
    chk("trace_pp3", trace[3], {4'h1, 4'h3, 2'b11});
    chk("12x34", out_r0, 16'h03A8);

    // Consumer back-pressure, then a handshake with a new request already waiting.
    @(negedge clk) out_ready = 1'b0;
    run_op(8'h0F, 8'h10, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_r", out_r0, 16'h00F0);
      chk("hold_rdy_busy", {in_ready0, busy0}, 2'b01);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_a = 8'h03; in_b = 8'h05; cfg_mode = 8'h00;
    @(posedge clk); @(negedge clk);
    chk("hs_idle", {in_ready0, busy0, out_valid0}, 3'b100);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("hs_next_accept", busy0, 1'b1);
    for (int i = 0; i < 10 && !out_valid0; i++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("3x5", {out_valid0, out_r0}, {1'b1, 16'h000F});

    @(negedge clk) stub = 1'b1;
    run_op(8'h5A, 8'hA5, 8'h1B);
    chk("stub_wrap", out_r0, 16'h1FDF);
    chk("stub_sat", out_r1, 16'hFFFF);
    @(negedge clk) stub = 1'b0;

    // Flush in IDLE blocks acceptance.
    in_valid = 1'b1; flush = 1'b1; in_a = 8'h77; in_b = 8'h77;
    @(posedge clk); @(negedge clk);
    chk("idle_flush", {in_ready0, busy0}, 2'b10);
    in_valid = 1'b0; flush = 1'b0;

    // Flush in PP2.
    @(negedge clk) begin in_valid = 1'b1; in_a = 8'h99; in_b = 8'h66; end
    @(posedge clk); @(negedge clk) in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk) flush = 1'b1;
    @(posedge clk); @(negedge clk) flush = 1'b0;
    chk("flush_idle", {busy0, out_valid0, in_ready0}, 3'b001);
    chk("flush_hold", {out_r0, out_r1}, {16'h1FDF, 16'hFFFF});
    repeat (8) @(negedge clk);

    // Asynchronous reset during PP1.
    @(negedge clk) in_valid = 1'b1;
    @(posedge clk); @(negedge clk) in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mul", {mul_en0, mul_a0, mul_b0, mul_mode0}, 11'h0);
    chk("arst_ctl", {in_ready0, busy0, out_valid0}, 3'b100);
    chk("arst_out", {out_r0, out_r1}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid0, 1'b0);
    end

    run_op(8'h80, 8'h02, 8'h55);
    chk("80x02", out_r0, 16'h0100);
    @(posedge clk); @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_8x8_seq_ctrl.md
MULT_8X8_SEQ_CTRL -- requirements
Module: mult_8x8_seq_ctrl

Interface
REQ-001 Parameter: SAT, default 0, overflow policy (0 = wrap modulo 2^16, 1 = saturate to 0xFFFF).
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand request.
REQ-005 in_ready  output  1  controller accepts operands.
REQ-006 in_a  input  8  multiplicand A.
REQ-007 in_b  input  8  multiplier B.
REQ-008 cfg_mode  input  8  per-quadrant 4x4 mode: [1:0] LL, [3:2] LH, [5:4] HL, [7:6] HH.
REQ-009 flush  input  1  synchronous abort of the operation in flight.
REQ-010 mul_en  output  1  shared 4x4 multiplier operand valid.
REQ-011 mul_a  output  4  nibble to shared 4x4 multiplier A port.
REQ-012 mul_b  output  4  nibble to shared 4x4 multiplier B port.
REQ-013 mul_mode  output  2  mode select: 00 exact, 01 N1, 10 R2, 11 reserved, passed through unchanged.
REQ-014 mul_r  input  8  combinational product from the shared 4x4 multiplier, same cycle.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_r  output  16  8x8 product.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, PP0, PP1, PP2, PP3, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; acceptance = in_valid & in_ready at a rising edge.
REQ-021 On acceptance, in_a, in_b and cfg_mode SHALL be registered, the 17-bit accumulator SHALL clear to 0, and the state SHALL go to PP0.
REQ-022 Quadrant schedule: PP0 = (A[3:0], B[3:0], shift 0, cfg[1:0]); PP1 = (A[3:0], B[7:4], shift 4, cfg[3:2]); PP2 = (A[7:4], B[3:0], shift 4, cfg[5:4]); PP3 = (A[7:4], B[7:4], shift 8, cfg[7:6]).
REQ-023 In each PPn state, mul_en SHALL be 1 and mul_a, mul_b and mul_mode SHALL be driven per REQ-022; at the closing edge, acc SHALL become acc + (mul_r << shift), computed at 17 bits.
REQ-024 The sequence PP0->PP1->PP2->PP3->DONE SHALL advance one state per cycle with no stalls.
REQ-025 Outside PPn states, mul_en, mul_a, mul_b and mul_mode SHALL all be 0.
REQ-026 Latency: with acceptance at edge T, out_valid SHALL be 1 from edge T+5, i.e. 5 cycles.
REQ-027 In DONE, out_valid SHALL be 1 and out_r SHALL be held stable until out_valid & out_ready; that edge SHALL return the state to IDLE.
REQ-028 With SAT=0, out_r SHALL equal acc[15:0]; with SAT=1, out_r SHALL be 0xFFFF when acc[16]=1, else acc[15:0].
REQ-029 In IDLE, out_valid SHALL be 0 and out_r SHALL retain the last result (0 after reset).
REQ-030 flush=1 at an edge in any PPn or DONE state SHALL force IDLE, discard the result and leave out_r unchanged; flush has priority over out_ready and over acceptance.
REQ-031 flush in IDLE SHALL block acceptance in that cycle, with in_ready still 1.
REQ-032 A new acceptance SHALL NOT be possible in the same cycle as a DONE handshake; the next acceptance is possible no earlier than the following cycle.
REQ-033 Operand or cfg_mode changes after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-034 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, acc=0, out_r=0, out_valid=0, busy=0, mul_en=0, mul_a=0, mul_b=0, mul_mode=0, and in_ready=1.
REQ-035 Reset asserted mid-operation SHALL abandon the operation; no out_valid SHALL follow release.

Verification (bench models mul_r as an exact 4x4 product unless stated)
REQ-036 A=0xFF, B=0xFF, cfg=0x00, out_ready=1 -> out_valid at T+5, out_r=0xFE01, mul_mode=00 throughout.
REQ-037 cfg=0xE4, A=0x12, B=0x34 -> mul_mode sequence 00, 01, 10, 11 over PP0..PP3, mul_a/mul_b sequence (2,4), (2,3), (1,4), (1,3), out_r=0x03A8.
REQ-038 out_ready=0 for 10 cycles after out_valid -> out_r stable, in_ready=0, busy=1; out_ready=1 -> IDLE on the next cycle.
REQ-039 Stub mul_r=0xFF in every state -> SAT=0 gives out_r=0x1FDF; SAT=1 gives out_r=0xFFFF.
REQ-040 flush in PP2 -> IDLE next cycle, no out_valid, out_r holds the previous result; rst_n low in PP1 -> all outputs take reset values asynchronously.
